// File: rtl/wave_rom_seq_if.sv
// Purpose: handshake, ROM and sample bus between a wave_rom_seq instance and its
//          environment (controller plus the four waveform ROMs).
// Signals: run/auto_en          generation enable / waveform auto-cycling
//          cfg_valid/cfg_ready   config handshake carrying cfg_sel/cfg_step/cfg_amp
//          rom_ena/rom_addr      one-hot ROM enables and shared ROM address
//          rom_douta             four ROM outputs concatenated, ROM k at [k*DATA_W +: DATA_W]
//          wave/wave_valid       scaled sample and its qualifier
//          cur_sel/period_tick   active waveform and per-period pulse
interface wave_rom_seq_if #(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ACC_W  = 16
);
  logic                run;
  logic                auto_en;
  logic                cfg_valid;
  logic                cfg_ready;
  logic [1:0]          cfg_sel;
  logic [ACC_W-1:0]    cfg_step;
  logic [7:0]          cfg_amp;
  logic [3:0]          rom_ena;
  logic [ADDR_W-1:0]   rom_addr;
  logic [4*DATA_W-1:0] rom_douta;
  logic [DATA_W-1:0]   wave;
  logic                wave_valid;
  logic [1:0]          cur_sel;
  logic                period_tick;

  // Environment side: controller and ROMs.
  modport master (
    output run, auto_en, cfg_valid, cfg_sel, cfg_step, cfg_amp, rom_douta,
    input  cfg_ready, rom_ena, rom_addr, wave, wave_valid, cur_sel, period_tick
  );

  // Sequencer side.
  modport slave (
    input  run, auto_en, cfg_valid, cfg_sel, cfg_step, cfg_amp, rom_douta,
    output cfg_ready, rom_ena, rom_addr, wave, wave_valid, cur_sel, period_tick
  );
endinterface

// File: rtl/wave_rom_seq.sv
// Purpose: phase-accumulator sequencer sharing four 512x8 waveform ROMs
//          (0 square, 1 sawtooth, 2 triangle, 3 sine) over one address path,
//          aligning the selected ROM output to its 1-cycle read latency and
//          scaling it by an amplitude code. Configuration is taken over a
//          valid/ready handshake and applied at period boundaries.
// Ports:   clk   system clock
//          rstn  asynchronous active-low reset
//          bus   wave_rom_seq_if.slave (config handshake, ROM bus, sample out)
module wave_rom_seq #(
  parameter int unsigned ADDR_W       = 9,
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned ACC_W        = 16,
  parameter int unsigned STEP_RST     = 1 << (ACC_W - ADDR_W),
  parameter int unsigned AUTO_PERIODS = 4
) (
  input  logic           clk,
  input  logic           rstn,
  wave_rom_seq_if.slave  bus
);

  localparam int unsigned CNT_W  = (AUTO_PERIODS > 1) ? $clog2(AUTO_PERIODS) : 1;
  localparam int unsigned AMP_W  = 8;
  localparam int unsigned PROD_W = DATA_W + AMP_W + 1;

  // Control state
  logic [ACC_W-1:0]  acc_q,   acc_d;
  logic [1:0]        sel_q,   sel_d;
  logic [ACC_W-1:0]  step_q,  step_d;
  logic [AMP_W-1:0]  amp_q,   amp_d;
  logic              pend_q,  pend_d;
  logic [1:0]        psel_q,  psel_d;
  logic [ACC_W-1:0]  pstep_q, pstep_d;
  logic [AMP_W-1:0]  pamp_q,  pamp_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;
  logic              tick_q,  tick_d;
  logic              ready_q, ready_d;

  // Datapath pipeline
  logic [1:0]        sel_d1_q;
  logic [AMP_W-1:0]  amp_d1_q;
  logic              vld_d1_q;
  logic [DATA_W-1:0] wave_q,  wave_d;
  logic              wvld_q;

  logic [ACC_W:0]    sum;
  logic              carry;
  logic              xfer;
  logic              apply;
  logic [DATA_W-1:0] samp;
  logic [AMP_W:0]    amp_p1;
  logic [PROD_W-1:0] prod;

  // Next-state: accumulator, config apply, auto-cycling
  always_comb begin
    sum     = {1'b0, acc_q} + {1'b0, step_q};
    carry   = bus.run & sum[ACC_W];
    xfer    = bus.cfg_valid & ready_q;
    // With run low there is no boundary to wait for, so apply on the next clock.
    apply   = pend_q & (~bus.run | carry);

    acc_d   = bus.run ? sum[ACC_W-1:0] : '0;
    tick_d  = carry;
    sel_d   = sel_q;
    step_d  = step_q;
    amp_d   = amp_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    psel_d  = psel_q;
    pstep_d = pstep_q;
    pamp_d  = pamp_q;

    if (apply) begin
      sel_d  = psel_q;
      step_d = pstep_q;
      amp_d  = pamp_q;
      pend_d = 1'b0;
      cnt_d  = '0;
    end else if (!bus.run) begin
      cnt_d  = '0;
    end else if (bus.auto_en && !pend_q && carry) begin
      if (cnt_q == CNT_W'(AUTO_PERIODS - 1)) begin
        sel_d = sel_q + 2'd1;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    // xfer needs ready_q, which is low whenever a config is pending, so it never
    // collides with apply.
    if (xfer) begin
      pend_d  = 1'b1;
      psel_d  = bus.cfg_sel;
      pstep_d = bus.cfg_step;
      pamp_d  = bus.cfg_amp;
    end

    ready_d = ~pend_d;
  end

  // Stage 2: pick the ROM that was addressed with the delayed sel, then scale
  always_comb begin
    samp = '0;
    for (int k = 0; k < 4; k++) begin
      if (sel_d1_q == 2'(k)) samp = bus.rom_douta[k*DATA_W +: DATA_W];
    end
    amp_p1 = {1'b0, amp_d1_q} + (AMP_W+1)'(1);
    prod   = PROD_W'(samp) * PROD_W'(amp_p1);
    wave_d = DATA_W'(prod >> AMP_W);
  end

  // State registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc_q    <= '0;
      sel_q    <= '0;
      step_q   <= ACC_W'(STEP_RST);
      amp_q    <= '1;
      pend_q   <= 1'b0;
      psel_q   <= '0;
      pstep_q  <= '0;
      pamp_q   <= '0;
      cnt_q    <= '0;
      tick_q   <= 1'b0;
      ready_q  <= 1'b1;
      sel_d1_q <= '0;
      amp_d1_q <= '0;
      vld_d1_q <= 1'b0;
      wave_q   <= '0;
      wvld_q   <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      sel_q    <= sel_d;
      step_q   <= step_d;
      amp_q    <= amp_d;
      pend_q   <= pend_d;
      psel_q   <= psel_d;
      pstep_q  <= pstep_d;
      pamp_q   <= pamp_d;
      cnt_q    <= cnt_d;
      tick_q   <= tick_d;
      ready_q  <= ready_d;
      sel_d1_q <= sel_q;
      amp_d1_q <= amp_q;
      vld_d1_q <= bus.run;
      wave_q   <= wave_d;
      wvld_q   <= vld_d1_q;
    end
  end

  // ROM address/enable follow run directly so a read is issued in the first run cycle.
  assign bus.rom_addr    = bus.run ? acc_q[ACC_W-1 -: ADDR_W] : '0;
  assign bus.rom_ena     = bus.run ? 4'(4'b0001 << sel_q) : 4'b0000;
  assign bus.cfg_ready   = ready_q;
  assign bus.wave        = wave_q;
  assign bus.wave_valid  = wvld_q;
  assign bus.cur_sel     = sel_q;
  assign bus.period_tick = tick_q;

endmodule

// File: tb/tb_wave_rom_seq.sv
// Bench for wave_rom_seq: ROM k returns (addr + 10*k) mod 256. A cycle model
// tracks address/select/config state; every generated sample's expected value
// goes into a queue that a separate monitor drains whenever wave_valid is high.
module tb_wave_rom_seq;
  localparam int unsigned ADDR_W = 9;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned ACC_W  = 16;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  wave_rom_seq_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ACC_W(ACC_W)) bus ();

  wave_rom_seq #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ACC_W(ACC_W)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  // Four single-port ROMs with one cycle of read latency
  logic [7:0] rom_q [4];
  always @(posedge clk) begin
    for (int k = 0; k < 4; k++)
      if (bus.rom_ena[k]) rom_q[k] <= 8'(int'(bus.rom_addr) + k * 10);
  end
  assign bus.rom_douta = {rom_q[3], rom_q[2], rom_q[1], rom_q[0]};

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  // Model state (value during the current cycle)
  int m_acc, m_sel, m_step, m_amp, m_pend, m_psel, m_pstep, m_pamp, m_cnt, m_tick, m_ready;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s t=%0t got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_acc = 0; m_sel = 0; m_step = 128; m_amp = 255; m_pend = 0;
    m_psel = 0; m_pstep = 0; m_pamp = 0; m_cnt = 0; m_tick = 0; m_ready = 1;
  endtask

  // Called at a negedge with this cycle's inputs already driven.
  task automatic cyc();
    int addr, sum, nacc, carry, xfer, apply, d;
    #1;
    addr = bus.run ? (m_acc >> 7) : 0;
    chk("rom_addr", int'(bus.rom_addr), addr);
    chk("rom_ena", int'(bus.rom_ena), bus.run ? (1 << m_sel) : 0);
    chk("period_tick", int'(bus.period_tick), m_tick);
    chk("cur_sel", int'(bus.cur_sel), m_sel);
    chk("cfg_ready", int'(bus.cfg_ready), m_ready);
    if (bus.run) begin
      d = (addr + m_sel * 10) % 256;
      exp_q.push_back((d * (m_amp + 1)) / 256);
    end
    xfer  = (bus.cfg_valid && m_ready) ? 1 : 0;
    carry = 0;
    nacc  = 0;
    if (bus.run) begin
      sum   = m_acc + m_step;
      carry = (sum > 65535) ? 1 : 0;
      nacc  = sum % 65536;
    end
    apply  = (m_pend && (!bus.run || carry)) ? 1 : 0;
    m_tick = carry;
    m_acc  = nacc;
    if (apply) begin
      m_sel = m_psel; m_step = m_pstep; m_amp = m_pamp; m_pend = 0; m_cnt = 0;
    end else if (!bus.run) begin
      m_cnt = 0;
    end else if (bus.auto_en && !m_pend && carry) begin
      m_cnt++;
      if (m_cnt == 4) begin
        m_cnt = 0;
        m_sel = (m_sel + 1) % 4;
      end
    end
    if (xfer) begin
      m_pend = 1; m_psel = int'(bus.cfg_sel); m_pstep = int'(bus.cfg_step); m_pamp = int'(bus.cfg_amp);
    end
    m_ready = m_pend ? 0 : 1;
    @(negedge clk);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rstn && bus.wave_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL wave_unexpected t=%0t got %0d expected no sample", $time, bus.wave);
      end else begin
        chk("wave", int'(bus.wave), exp_q.pop_front());
      end
    end
  end

  // Config transfer with run low, then three run cycles hitting addr 0, 200, 400
  task automatic amp_case(input int amp, input int exp200);
    bus.cfg_valid = 1'b1; bus.cfg_sel = 2'd0; bus.cfg_step = 16'd25600; bus.cfg_amp = 8'(amp);
    cyc();
    bus.cfg_valid = 1'b0;
    chk("amp_cfg_ready_low", int'(bus.cfg_ready), 0);
    cyc();
    chk("amp_cfg_ready_back", int'(bus.cfg_ready), 1);
    bus.run = 1'b1;
    cyc(); cyc(); cyc();
    chk("amp_wave200", int'(bus.wave), exp200);
    bus.run = 1'b0;
    repeat (3) cyc();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog t=%0t got timeout expected finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.run = 1'b0; bus.auto_en = 1'b0; bus.cfg_valid = 1'b0;
    bus.cfg_sel = 2'd0; bus.cfg_step = '0; bus.cfg_amp = '0;
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    chk("rst_cfg_ready", int'(bus.cfg_ready), 1);
    chk("rst_wave", int'(bus.wave), 0);
    chk("rst_wave_valid", int'(bus.wave_valid), 0);
    chk("rst_cur_sel", int'(bus.cur_sel), 0);
    chk("rst_period_tick", int'(bus.period_tick), 0);
    chk("rst_rom_ena", int'(bus.rom_ena), 0);
    chk("rst_rom_addr", int'(bus.rom_addr), 0);
    @(negedge clk);
    rstn = 1'b1;

    // Default square wave: one address per clock, tick every 512 cycles
    bus.run = 1'b1;
    cyc();
    chk("start_valid_lat1", int'(bus.wave_valid), 0);
    cyc();
    chk("start_valid_lat2", int'(bus.wave_valid), 1);
    for (int i = 0; i < 598; i++) cyc();
    n = 0;
    while (bus.rom_addr != 9'd100 && n < 1000) begin cyc(); n++; end
    chk("reach_addr100", int'(bus.rom_addr), 100);

    // Switch to sine, step 4 addresses per clock, applied at the wrap
    bus.cfg_valid = 1'b1; bus.cfg_sel = 2'd3; bus.cfg_step = 16'h0200; bus.cfg_amp = 8'd255;
    cyc();
    bus.cfg_valid = 1'b0;
    chk("cfg_ready_low", int'(bus.cfg_ready), 0);
    n = 0;
    while (bus.cur_sel != 2'd3 && n < 1000) begin cyc(); n++; end
    chk("apply_at_wrap_cycles", n, 411);
    chk("apply_rom_ena", int'(bus.rom_ena), 8);
    chk("apply_rom_addr", int'(bus.rom_addr), 0);
    chk("apply_cfg_ready", int'(bus.cfg_ready), 1);
    for (int i = 0; i < 128; i++) cyc();
    chk("tick_period_128", int'(bus.period_tick), 1);
    for (int i = 0; i < 200; i++) cyc();

    // Drain: wave_valid holds one more cycle, then falls
    bus.run = 1'b0;
    cyc();
    chk("drain_valid_1", int'(bus.wave_valid), 1);
    cyc();
    chk("drain_valid_0", int'(bus.wave_valid), 0);
    cyc();

    // Amplitude scaling of ROM sample 200
    amp_case(127, 100);
    amp_case(255, 200);
    amp_case(0, 0);

    // Back to default step, then auto-cycle
    bus.cfg_valid = 1'b1; bus.cfg_sel = 2'd0; bus.cfg_step = 16'd128; bus.cfg_amp = 8'd255;
    cyc();
    bus.cfg_valid = 1'b0;
    cyc(); cyc();
    bus.auto_en = 1'b1;
    bus.run = 1'b1;
    for (int t = 0; t < 10240; t++) begin
      if (t == 10100) begin
        bus.cfg_valid = 1'b1; bus.cfg_sel = 2'd2; bus.cfg_step = 16'd128; bus.cfg_amp = 8'd255;
      end
      cyc();
      bus.cfg_valid = 1'b0;
      if ((t + 1) % 2048 == 0 && (t + 1) <= 8192)
        chk("auto_sel_new", int'(bus.cur_sel), ((t + 1) / 2048) % 4);
      if ((t + 1) % 2048 == 2047 && (t + 1) < 8192)
        chk("auto_sel_old", int'(bus.cur_sel), ((t + 1) / 2048) % 4);
      if (t + 1 == 10239)
        chk("override_pre", int'(bus.cur_sel), 0);
    end
    chk("override_sel", int'(bus.cur_sel), 2);

    // Async reset mid-period at addr 300 on the triangle ROM
    n = 0;
    while (bus.rom_addr != 9'd300 && n < 1000) begin cyc(); n++; end
    chk("pre_rst_addr", int'(bus.rom_addr), 300);
    chk("pre_rst_sel", int'(bus.cur_sel), 2);
    #2;
    rstn = 1'b0;
    #1;
    chk("arst_wave", int'(bus.wave), 0);
    chk("arst_wave_valid", int'(bus.wave_valid), 0);
    chk("arst_period_tick", int'(bus.period_tick), 0);
    chk("arst_cur_sel", int'(bus.cur_sel), 0);
    chk("arst_cfg_ready", int'(bus.cfg_ready), 1);
    chk("arst_rom_addr", int'(bus.rom_addr), 0);
    exp_q.delete();
    model_reset();
    bus.auto_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    cyc();
    chk("restart_valid_lat1", int'(bus.wave_valid), 0);
    cyc();
    chk("restart_valid_lat2", int'(bus.wave_valid), 1);
    for (int i = 0; i < 48; i++) cyc();
    bus.run = 1'b0;
    repeat (4) cyc();
    chk("queue_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/wave_rom_seq.md
Name: wave_rom_seq

Overview:
- Sequencer that shares four 512x8 single-port waveform ROMs (square/fang, sawtooth/juchi, triangle/sanjiao, sine/sin) behind one address/data path.
- Generates ROM address from a phase accumulator, drives one-hot ROM enables, and aligns the selected ROM output to the 1-cycle ROM read latency.
- Applies amplitude scaling to the aligned sample.
- Accepts waveform, frequency and amplitude configuration through a valid/ready handshake and applies it glitch-free at period boundaries; optional auto-cycling through the four waveforms.

Parameters:
- ADDR_W, 9, ROM address width
- DATA_W, 8, ROM/output sample width
- ACC_W, 16, phase accumulator width (must be >= ADDR_W)
- STEP_RST, 1<<(ACC_W-ADDR_W), reset phase step: one ROM address per clock
- AUTO_PERIODS, 4, periods per waveform in auto mode (>= 1)

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- run  in  1  generation enable
- auto_en  in  1  auto-cycle waveforms
- cfg_valid  in  1  config request
- cfg_ready  out  1  config slot free
- cfg_sel  in  2  waveform select: 0 fang, 1 juchi, 2 sanjiao, 3 sin
- cfg_step  in  ACC_W  phase increment per clock
- cfg_amp  in  8  amplitude code
- rom_ena  out  4  one-hot ROM enable: bit0 fang, bit1 juchi, bit2 sanjiao, bit3 sin
- rom_addr  out  ADDR_W  shared ROM address
- rom_douta  in  4*DATA_W  ROM outputs concatenated, ROM k at [k*DATA_W +: DATA_W]
- wave  out  DATA_W  scaled sample
- wave_valid  out  1  wave carries a live sample
- cur_sel  out  2  active waveform
- period_tick  out  1  one-cycle pulse per accumulator wrap

Behaviour:
- Reset (async, all registers):
  - acc=0, sel=0, step=STEP_RST, amp=255, no pending config, auto counter=0.
  - Outputs: cfg_ready=1, wave=0, wave_valid=0, cur_sel=0, period_tick=0.
  - rom_ena=0 and rom_addr=0 until run is high.
- Accumulator:
  - While run=1, acc <= acc+step each clock; carry is taken from an ACC_W+1-bit sum.
  - rom_addr = acc[ACC_W-1 -: ADDR_W].
  - rom_ena = one-hot(sel).
  - period_tick is high for exactly the cycle after the carry occurs.
- run=0:
  - acc cleared to 0, auto counter cleared, rom_ena=0, rom_addr=0.
  - The pipeline drains; wave_valid falls 2 cycles after run falls.
- Config handshake:
  - Transfer occurs when cfg_valid & cfg_ready. The transferred values are latched as pending and cfg_ready goes low the next cycle.
  - Apply point: the pending config is loaded into sel/step/amp at the next carry while run=1, or on the next clock if run=0.
  - cfg_ready returns high the cycle after the apply.
  - acc is not cleared on apply; the wrap remainder is kept.
  - Apply clears the auto counter.
  - A new transfer is impossible while a config is pending.
- Auto mode:
  - Active when auto_en=1 and no config is pending. The auto counter increments on each carry.
  - When the counter reaches AUTO_PERIODS-1 and another carry occurs: sel <= sel+1 (wraps 3->0) and the counter clears.
  - A pending config wins over the auto advance on the same carry.
- Datapath, 2-cycle latency from rom_addr/rom_ena to wave:
  - Stage 1: register sel_d1, amp_d1, and valid_d1 = run.
  - Stage 2: wave <= (rom_douta[sel_d1*DATA_W +: DATA_W] * (amp_d1+1)) >> 8, truncated to DATA_W. wave_valid <= valid_d1.
  - amp=255 gives identity; amp=0 gives data>>8 (=0 for DATA_W=8).
  - On a sel switch, the sample in flight is muxed with its own delayed sel, so the switch is glitch-free.
- cur_sel reflects the registered sel; it changes in the same cycle rom_ena changes.
- step=0:
  - rom_addr freezes and no period_tick occurs.
  - A pending config applies only after run drops.
- Async reset mid-run: all state returns to reset values immediately. After release, generation restarts at addr 0 with sel 0 when run=1.

Test Plan:
- Reset defaults, run=1, auto_en=0, ROM k returns (addr+k*10)[7:0] -> rom_ena=0001; rom_addr 0,1,...,511,0; wave equals fang data 2 cycles later; period_tick every 512 cycles.
- At rom_addr=100, send cfg sel=3, step=0x0200, amp=255 -> cfg_ready=0; rom_ena stays 0001 until wrap, then 1000; rom_addr steps by 4; period_tick every 128 cycles; cfg_ready=1 the cycle after apply.
- auto_en=1, AUTO_PERIODS=4, default step -> cur_sel 0->1->2->3->0, changing every 2048 cycles; a config pending at a boundary overrides the auto advance.
- amp=127 with ROM sample 200 -> wave=100; amp=255 -> 200; amp=0 -> 0.
- run=0, then cfg handshake -> applied the next clock; cfg_ready high 2 cycles after transfer; wave_valid low 2 cycles after run fell.
- Assert rstn mid-period at addr 300, sel 2 -> outputs zero immediately without a clock edge; after release with run=1, addr restarts at 0 with rom_ena=0001.
